// File: rtl/space_pkg.sv
// space_pkg: screen geometry and controller state encoding shared by the spaceship blocks.
package space_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int SCREEN_CORDW = 16;
  typedef enum logic [1:0] {WAIT_SAMPLE = 2'd0, TRACK = 2'd1, FROZEN = 2'd2} ctrl_state_t;
endpackage

// File: rtl/tilt_filter.sv
// tilt_filter: IIR-smoothed X tilt (first sample loads directly) turned into a dead-zoned, capped step and direction.
module tilt_filter #(
  parameter int ACCEL_W     = 16,
  parameter int DEAD_ZONE   = 16,
  parameter int SPEED_SHIFT = 5,
  parameter int MAX_STEP    = 8,
  parameter int STEP_W      = $clog2(MAX_STEP + 1)
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic               accept,
  input  logic [ACCEL_W-1:0] accel_x,
  output logic [STEP_W-1:0]  step,
  output logic               neg
);
  localparam logic [ACCEL_W:0] DZ = (ACCEL_W + 1)'(DEAD_ZONE);
  localparam logic [ACCEL_W:0] MS = (ACCEL_W + 1)'(MAX_STEP);
  logic                      loaded_q;
  logic [ACCEL_W-1:0]        filt_q, filt_d;
  logic signed [ACCEL_W:0]   xe, fe, diff, upd;
  logic [ACCEL_W:0]          mag, shifted;
  always_comb begin
    xe      = {accel_x[ACCEL_W-1], accel_x};
    fe      = {filt_q[ACCEL_W-1], filt_q};
    diff    = xe - fe;
    upd     = fe + (diff >>> 2);
    filt_d  = loaded_q ? upd[ACCEL_W-1:0] : accel_x;
    mag     = fe[ACCEL_W] ? -fe : fe;
    shifted = (mag - DZ) >> SPEED_SHIFT;
    step    = mag <= DZ ? '0 : (shifted > MS ? STEP_W'(MAX_STEP) : shifted[STEP_W-1:0]);
    neg     = filt_q[ACCEL_W-1];
  end
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      loaded_q <= 1'b0;
      filt_q   <= '0;
    end else if (accept) begin
      loaded_q <= 1'b1;
      filt_q   <= filt_d;
    end
  end
endmodule

// File: rtl/spaceship_controller.sv
// spaceship_controller: tilt-driven ship X position, one clamped move per frame, frozen for a while after a hit.
module spaceship_controller
  import space_pkg::*;
#(
  parameter int H_RES         = 640,
  parameter int SCREEN_CORDW  = 16,
  parameter int ACCEL_W       = 16,
  parameter int SHIP_W        = 34,
  parameter int START_X       = 303,
  parameter int START_Y       = 300,
  parameter int DEAD_ZONE     = 16,
  parameter int SPEED_SHIFT   = 5,
  parameter int MAX_STEP      = 8,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    frame,
  input  logic                    accel_valid,
  output logic                    accel_ready,
  input  logic [ACCEL_W-1:0]      accel_x,
  input  logic                    hit,
  output logic [SCREEN_CORDW-1:0] ship_x,
  output logic [SCREEN_CORDW-1:0] ship_y,
  output logic [1:0]              state
);
  localparam int STEP_W = $clog2(MAX_STEP + 1);
  localparam int CNT_W  = $clog2(FREEZE_FRAMES + 1);
  localparam logic signed [SCREEN_CORDW:0] X_MAX = (SCREEN_CORDW + 1)'(H_RES - SHIP_W);
  ctrl_state_t                    state_q;
  logic                           ready_q, accept, neg;
  logic [CNT_W-1:0]               freeze_cnt_q;
  logic [STEP_W-1:0]              step;
  logic [SCREEN_CORDW-1:0]        ship_x_q, ship_x_d;
  logic signed [SCREEN_CORDW:0]   cur, delta, mv;
  assign accel_ready = ready_q & ~frame;
  assign accept      = accel_valid & accel_ready;
  assign ship_x      = ship_x_q;
  assign ship_y      = SCREEN_CORDW'(START_Y);
  assign state       = state_q;
  tilt_filter #(
    .ACCEL_W(ACCEL_W), .DEAD_ZONE(DEAD_ZONE), .SPEED_SHIFT(SPEED_SHIFT),
    .MAX_STEP(MAX_STEP), .STEP_W(STEP_W)
  ) u_filter (
    .clk_pix(clk_pix), .rst_n(rst_n), .accept(accept), .accel_x(accel_x),
    .step(step), .neg(neg)
  );
  // one extra bit so a move past either edge shows up as negative or above X_MAX instead of wrapping
  always_comb begin
    cur      = {1'b0, ship_x_q};
    delta    = {{(SCREEN_CORDW + 1 - STEP_W){1'b0}}, step};
    mv       = neg ? cur - delta : cur + delta;
    ship_x_d = mv[SCREEN_CORDW] ? '0 : (mv > X_MAX ? X_MAX[SCREEN_CORDW-1:0] : mv[SCREEN_CORDW-1:0]);
  end
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      state_q      <= WAIT_SAMPLE;
      freeze_cnt_q <= '0;
      ship_x_q     <= SCREEN_CORDW'(START_X);
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        WAIT_SAMPLE: if (accept) state_q <= TRACK;
        TRACK: begin
          if (hit) begin
            state_q      <= FROZEN;
            freeze_cnt_q <= CNT_W'(FREEZE_FRAMES);
          end else if (frame) begin
            ship_x_q <= ship_x_d;
          end
        end
        FROZEN: begin
          if (hit) begin
            freeze_cnt_q <= CNT_W'(FREEZE_FRAMES);
          end else if (frame) begin
            freeze_cnt_q <= freeze_cnt_q - 1'b1;
            if (freeze_cnt_q == CNT_W'(1)) state_q <= TRACK;
          end
        end
        default: state_q <= WAIT_SAMPLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spaceship_controller.sv
// tb_spaceship_controller: directed and random tilt/frame/hit traffic against an integer reference model.
module tb_spaceship_controller;
  logic        clk_pix = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic        accel_valid = 1'b0;
  logic        hit = 1'b0;
  logic [15:0] accel_x = '0;
  logic        accel_ready;
  logic [15:0] ship_x, ship_y;
  logic [1:0]  state;
  int errors = 0;
  int checks = 0;
  int m_filt, m_x, m_cnt, m_mode;
  bit m_loaded, m_rdy;
  spaceship_controller dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .accel_valid(accel_valid),
    .accel_ready(accel_ready), .accel_x(accel_x), .hit(hit),
    .ship_x(ship_x), .ship_y(ship_y), .state(state)
  );
  always #5 clk_pix = ~clk_pix;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int floor_div4(input int d);
    return d >= 0 ? d / 4 : -((-d + 3) / 4);
  endfunction
  function automatic int step_of(input int f);
    int m;
    m = f < 0 ? -f : f;
    if (m <= 16) return 0;
    m = (m - 16) / 32;
    return m > 8 ? 8 : m;
  endfunction
  function automatic int clamp_x(input int x);
    return x < 0 ? 0 : (x > 606 ? 606 : x);
  endfunction
  task automatic do_reset();
    @(negedge clk_pix);
    #2;
    rst_n = 1'b0;
    frame = 1'b0;
    accel_valid = 1'b0;
    hit = 1'b0;
    #1;
    check("rst_ship_x", ship_x, 303);
    check("rst_ship_y", ship_y, 300);
    check("rst_state", state, 0);
    check("rst_ready", accel_ready, 0);
    m_filt = 0; m_x = 303; m_cnt = 0; m_mode = 0; m_loaded = 0; m_rdy = 0;
    @(negedge clk_pix);
    rst_n = 1'b1;
    @(posedge clk_pix);
    m_rdy = 1;
    #1;
    check("ready_after_rst", accel_ready, 1);
  endtask
  task automatic cycle(input bit fr, input bit v, input int x, input bit h, output bit acc);
    int s;
    @(negedge clk_pix);
    frame = fr;
    accel_valid = v;
    accel_x = 16'(x);
    hit = h;
    #1;
    check("ready", accel_ready, m_rdy && !fr);
    acc = v && m_rdy && !fr;
    s = step_of(m_filt);
    @(posedge clk_pix);
    case (m_mode)
      0: if (acc) m_mode = 1;
      1: if (h) begin m_mode = 2; m_cnt = 60; end
         else if (fr) m_x = clamp_x(m_x + (m_filt < 0 ? -s : s));
      default: if (h) m_cnt = 60;
         else if (fr) begin if (m_cnt == 1) m_mode = 1; m_cnt--; end
    endcase
    if (acc) begin
      m_filt = m_loaded ? m_filt + floor_div4(x - m_filt) : x;
      m_loaded = 1;
    end
    m_rdy = 1;
    #1;
    check("ship_x", ship_x, m_x);
    check("state", state, m_mode);
  endtask
  task automatic cyc(input bit fr, input bit v, input int x, input bit h);
    bit a;
    cycle(fr, v, x, h, a);
  endtask
  initial begin
    bit pend_v, acc, fr, h;
    int pend_x;
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    check("idle_x", ship_x, 303);
    cyc(0, 1, 144, 0);
    check("first_track", state, 1);
    cyc(1, 0, 0, 0);
    check("first_move", ship_x, 307);
    do_reset();
    cyc(0, 1, 10, 0);
    cyc(0, 1, -16, 0);
    repeat (4) cyc(1, 0, 0, 0);
    check("dead_zone", ship_x, 303);
    do_reset();
    cyc(0, 1, 1000, 0);
    repeat (45) cyc(1, 0, 0, 0);
    check("clamp_hi", ship_x, 606);
    repeat (100) begin
      cyc(0, 1, -1000, 0);
      cyc(1, 0, 0, 0);
    end
    check("clamp_lo", ship_x, 0);
    do_reset();
    cyc(0, 1, 144, 0);
    cyc(0, 0, 0, 1);
    check("frozen", state, 2);
    repeat (59) cyc(1, 0, 0, 0);
    check("still_frozen", state, 2);
    cyc(1, 0, 0, 0);
    check("unfrozen", state, 1);
    check("frozen_no_move", ship_x, 303);
    cyc(1, 0, 0, 0);
    check("move_after_freeze", ship_x, 307);
    cyc(0, 0, 0, 1);
    repeat (30) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    repeat (59) cyc(1, 0, 0, 0);
    check("reload_frozen", state, 2);
    cyc(1, 0, 0, 0);
    check("reload_release", state, 1);
    cyc(1, 0, 0, 1);
    check("hit_frame_no_move", ship_x, 307);
    check("hit_frame_state", state, 2);
    do_reset();
    cyc(0, 0, 0, 1);
    check("hit_in_wait", state, 0);
    cyc(0, 1, 144, 0);
    cycle(1, 1, 400, 0, acc);
    check("stall_not_accepted", acc, 0);
    cyc(0, 1, 400, 0);
    cyc(1, 0, 0, 0);
    check("stall_one_update", ship_x, 313);
    do_reset();
    pend_v = 0;
    pend_x = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        pend_v = 0;
      end
      if (!pend_v) begin
        pend_v = $urandom_range(0, 1) == 1;
        pend_x = ($urandom_range(0, 9) == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 1400)) - 700;
      end
      fr = $urandom_range(0, 3) == 0;
      h  = $urandom_range(0, 39) == 0;
      cycle(fr, pend_v, pend_x, h, acc);
      if (acc) pend_v = 0;
    end
    check("final_ship_y", ship_y, 300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
